// File: rtl/tt_resp_pkg.sv
// Shared types and constants for the pin-interface register-file responder.
package tt_resp_pkg;

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    ACK   = 2'd3
  } resp_state_t;

  localparam int NREGS_DEFAULT = 4;
  localparam int TXN_W         = 8;

endpackage

// File: rtl/tt_sync2.sv
// Generic 2-flop level synchronizer with synchronous active-high reset to 0.
module tt_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tt_pin_responder.sv
// Register-file responder completing each pin request with a four-phase req/ack handshake.
// Build option: define TT_RESP_SYNC_EN to pass req through a 2-flop synchronizer.
module tt_pin_responder
  import tt_resp_pkg::*;
#(
  parameter int  NREGS  = NREGS_DEFAULT,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [TXN_W-1:0]  txn_count,
  output logic [1:0]        state
);

  // Handshake: the initiator raises req with we/addr/wdata stable; the request is
  // captured once, ack rises after execution and stays high until req falls, then
  // ack falls and the next request may be raised.
  localparam logic [TXN_W-1:0] TXN_ONE = 1;

  resp_state_t       st;
  logic              req_s;
  logic              primed;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [7:0]        h_wdata;
  logic [7:0]        regs [NREGS];

`ifdef TT_RESP_SYNC_EN
  logic [1:0] prime;

  tt_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (req_s)
  );

  // The synchronizer comes out of reset reading 0; hold DRAIN until it reflects the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime <= 2'd0;
    end else if (!prime[1]) begin
      prime <= prime + 2'd1;
    end
  end

  assign primed = prime[1];
`else
  assign req_s  = req;
  assign primed = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= DRAIN;
      ack       <= 1'b0;
      rdata     <= 8'h00;
      txn_count <= '0;
      h_we      <= 1'b0;
      h_addr    <= '0;
      h_wdata   <= 8'h00;
      regs      <= '{default: 8'h00};
    end else begin
      case (st)
        DRAIN: begin
          if (!req_s && primed) st <= IDLE;
        end
        IDLE: begin
          if (req_s) begin
            h_we    <= we;
            h_addr  <= addr;
            h_wdata <= wdata;
            st      <= EXEC;
          end
        end
        EXEC: begin
          if (h_we) begin
            regs[h_addr] <= h_wdata;
            rdata        <= h_wdata;
          end else begin
            rdata <= regs[h_addr];
          end
          txn_count <= txn_count + TXN_ONE;
          ack       <= 1'b1;
          st        <= ACK;
        end
        ACK: begin
          if (!req_s) begin
            ack <= 1'b0;
            st  <= IDLE;
          end
        end
        default: st <= DRAIN;
      endcase
    end
  end

  assign busy  = (st != IDLE);
  assign state = st;

endmodule

// File: tb/tb_tt_pin_responder.sv
// Self-checking bench for tt_pin_responder: transaction-level model plus per-cycle compare.
module tb_tt_pin_responder;

  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;
`ifdef TT_RESP_SYNC_EN
  localparam int SL      = 2;
  localparam int EXP_LAT = 3;
`else
  localparam int SL      = 0;
  localparam int EXP_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              ack;
  logic [7:0]        rdata;
  logic              busy;
  logic [7:0]        txn_count;
  logic [1:0]        state;

  tt_pin_responder #(.NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .txn_count (txn_count),
    .state     (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] mem [NREGS];
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata;
  logic [7:0] exp_txn;
  logic       exp_ack;
  logic       exp_busy;
  bit         chk_en = 1'b0;
  int         last_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
    exp_q.delete();
    exp_rdata = 8'h00;
    exp_txn   = 8'h00;
    exp_ack   = 1'b0;
    exp_busy  = 1'b1;
  endtask

  // Scoreboard: every cycle the outputs are meaningful, compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
      chk("ack", ack, exp_ack);
      chk("busy", busy, exp_busy);
      chk("rdata", rdata, exp_rdata);
      chk("txn_count", txn_count, exp_txn);
    end
  end

  // One handshake. Edge j=0 is the first edge seeing pin req high; the FSM sees it at
  // j=SL (E0), results land at E0+1, and ack falls on the first edge the FSM sees req low
  // while acknowledging. hold = edges after E0 before the pin is dropped.
  task automatic txn(input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                     input int hold);
    int f;
    f = (hold + 1 + SL > 2) ? hold + 1 + SL : 2;
    last_lat = -1;
    we    = w;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    for (int j = 0; j <= SL + f; j++) begin
      @(posedge clk);
      #1;
      if (ack && last_lat < 0) last_lat = j;
      if (j == SL) begin
        exp_busy = 1'b1;
        if (hold == 0) req = 1'b0;
      end
      if (j == SL + 1) begin
        if (w) begin
          mem[a] = d;
          exp_q.push_back(d);
        end else begin
          exp_q.push_back(mem[a]);
        end
        exp_txn++;
        exp_ack = 1'b1;
        we    = 1'($urandom_range(0, 1));
        addr  = ADDR_W'($urandom_range(0, NREGS - 1));
        wdata = 8'($urandom_range(0, 255));
      end
      if (hold > 0 && j == SL + hold) req = 1'b0;
      if (j == SL + f) begin
        exp_ack  = 1'b0;
        exp_busy = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = 8'h00;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (1 + SL) @(posedge clk);
    #1 exp_busy = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_txn", txn_count, 8'h00);

    txn(1'b1, 2'd2, 8'hA5, 1);
    chk("latency", last_lat, EXP_LAT);
    chk("wr_echo", rdata, 8'hA5);
    txn(1'b0, 2'd2, 8'h00, 2);
    chk("rd_a5", rdata, 8'hA5);
    chk("txn_two", txn_count, 8'h02);

    txn(1'b1, 2'd3, 8'h5A, 0);
    chk("early_drop_idle", busy, 1'b0);
    txn(1'b0, 2'd3, 8'h00, 1);
    chk("early_drop_wr", rdata, 8'h5A);

    // Reset lands on the execute edge of a write; req stays high across reset.
    we    = 1'b1;
    addr  = 2'd1;
    wdata = 8'h3C;
    req   = 1'b1;
    repeat (1 + SL) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_busy", busy, 1'b1);
    chk("hold_ack", ack, 1'b0);
    req = 1'b0;
    repeat (1 + SL) @(posedge clk);
    #1 exp_busy = 1'b0;
    txn(1'b0, 2'd1, 8'h00, 1);
    chk("rst_write_dropped", rdata, 8'h00);
    chk("rst_txn_one", txn_count, 8'h01);
    txn(1'b0, 2'd2, 8'h00, 1);
    chk("rst_clears_regs", rdata, 8'h00);

    for (int i = 0; i < 256; i++) begin
      txn(1'b0, 2'd0, 8'h00, 1);
      if (i == 253) chk("wrap_00", txn_count, 8'h00);
    end
    chk("wrap_end", txn_count, 8'h02);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_pin_responder.md
# tt_pin_responder

Register-file responder behind the Tiny Tapeout pin interface. The cocotb bench (through `tb`) acts as initiator on `ui_in`/`uio_in`; this block completes each request with a four-phase req/ack handshake. It performs one write or read on a small internal register file and returns data for the top level to drive onto `uo_out`/`uio_out`. The top level instantiates it and maps pins; reset is derived there as `rst = ~rst_n`.

## Interface
- `NREGS`, 4: number of 8-bit registers; power of two, 2..16.
- `ADDR_W`, $clog2(NREGS): address width; derived, never overridden.
- `clk`  in  1  design clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  initiator request level; may change asynchronously to `clk`.
- `we`  in  1  1 = write, 0 = read; sampled with the request.
- `addr`  in  ADDR_W  register index; sampled with the request.
- `wdata`  in  8  write data; sampled with the request.
- `ack`  out  1  acknowledge level.
- `rdata`  out  8  register value of the last completed transaction.
- `busy`  out  1  high whenever state is not IDLE.
- `txn_count`  out  8  number of completed transactions.

## Operation
- Internal `req_s` is `req` after the optional synchronizer (see Configuration).
- FSM states: DRAIN, IDLE, EXEC, ACK. Reset state is DRAIN.
- DRAIN: wait for `req_s` == 0, then go to IDLE. A request already high across reset is never executed.
- IDLE: on `req_s` == 1, capture `we`, `addr` and `wdata` into holding registers and go to EXEC.
- EXEC (one cycle):
  - Write: `regs[addr] <= wdata` and `rdata <= wdata` (echo).
  - Read: `rdata <= regs[addr]`.
  - In both cases `txn_count` increments, wrapping 255 -> 0, and the FSM goes to ACK with `ack <= 1`.
- ACK: hold `ack` = 1 while `req_s` == 1. On `req_s` == 0, `ack <= 0` and go to IDLE.
- `req_s` dropping while in EXEC does not abort the operation. The FSM still passes through ACK and leaves it on the next cycle.
- Pin changes to `we`, `addr` or `wdata` after capture have no effect.
- Reset values: `ack` 0, `rdata` 0x00, `busy` 1 (state DRAIN), `txn_count` 0, all registers 0x00.
- Reset mid-transaction: the in-flight operation is discarded. A write landing on the same edge as reset is not performed, and reset values win.

## Timing
- E0 is the first `clk` edge at which `req_s` is high in IDLE.
- Capture happens at E0. Register write, `rdata`, `txn_count` and `ack` all update at E0+1. `ack` is therefore visible one cycle after E0.
- Without sync, E0 is the first edge seeing pin `req` high. With sync, E0 is 2 edges later.
- Release: `ack` falls at the edge F0 where `req_s` is first low in ACK. With sync this is 2 edges after the pin falls.
- Minimum handshake without sync is 3 cycles: E0, EXEC, ACK with immediate release. A new request is accepted at the first edge after the return to IDLE.
- `busy` is registered state decode with no combinational path from inputs. `ack` and `rdata` are registered.

## Configuration
- `TT_RESP_SYNC_EN` defined: `req` passes through a 2-flop synchronizer (flops reset to 0) before the FSM. This adds 2 cycles to both the assert and release latency.
- `TT_RESP_SYNC_EN` undefined: `req_s = req` directly, and the bench must drive `req` synchronously to `clk`.
- `we`, `addr` and `wdata` are never synchronized. They must be stable from the moment `req` rises until `ack` rises.

## Structure
- Package `tt_resp_pkg` holds:
  - the state enum `resp_state_t` (DRAIN, IDLE, EXEC, ACK);
  - the `NREGS` default;
  - the `TXN_W` = 8 constant.
- One sub-module, `tt_sync2`: a generic 2-flop level synchronizer with synchronous active-high reset. It is instantiated only under `TT_RESP_SYNC_EN`.

## Test plan
- Reset held 5 cycles with `req`=0, then released -> one cycle of DRAIN, then `busy`=0, `ack`=0, `rdata`=0x00, `txn_count`=0.
- Write 0xA5 to addr 2, then read addr 2 -> each `ack` rises E0+1 after its `req_s`; read returns `rdata`=0xA5; `txn_count`=2.
- Hold `req`=1 through and after reset -> no `ack` and no register change until `req` goes 0 then 1; the first completed transaction gives `txn_count`=1.
- 256 back-to-back reads of addr 0 -> `txn_count` wraps to 0x00; every `ack` falls the cycle after `req_s` falls.
- Drop `req` one cycle after E0 (during EXEC) -> the write still lands, `ack` pulses exactly one cycle, then IDLE.
- With and without `TT_RESP_SYNC_EN` -> req-to-`ack` latency measured as 3 vs 1 cycles from the edge seeing pin `req` high.
